// File: rtl/traffic_phase_sched.sv
// traffic_phase_sched: timed two-road phase scheduler with min/max green, pedestrian walk phase
// and optional emergency preemption (enabled by defining EMERG_PREEMPT_EN, which adds the emerg port).
module traffic_phase_sched #(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 20,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1,
    parameter int WALK_T    = 6,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ta,
    input  logic       tb,
    input  logic       ped_req,
`ifdef EMERG_PREEMPT_EN
    input  logic       emerg,
`endif
    output logic [1:0] la,
    output logic [1:0] lb,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);
    localparam logic [2:0] A_GREEN   = 3'd0;
    localparam logic [2:0] A_YELLOW  = 3'd1;
    localparam logic [2:0] ALLRED_AB = 3'd2;
    localparam logic [2:0] B_GREEN   = 3'd3;
    localparam logic [2:0] B_YELLOW  = 3'd4;
    localparam logic [2:0] ALLRED_BA = 3'd5;
    localparam logic [2:0] PED_WALK  = 3'd6;
    localparam logic [2:0] PREEMPT   = 3'd7;

    // Timer values on the last cycle of each timed phase
    localparam logic [CNT_W-1:0] G_MIN  = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] G_MAX  = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] Y_END  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_END = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] W_END  = CNT_W'(WALK_T - 1);

    logic [2:0]       st, nxt;
    logic [CNT_W-1:0] timer;
    logic             ped_pending;
    logic             last_road;
    logic             emg;

`ifdef EMERG_PREEMPT_EN
    assign emg = emerg;
`else
    assign emg = 1'b0;
`endif

    // State, saturating phase timer, latched pedestrian request and last-served road
    always_ff @(posedge clk) begin
        if (rst) begin
            st          <= A_GREEN;
            timer       <= '0;
            ped_pending <= 1'b0;
            last_road   <= 1'b0;
        end else begin
            st          <= nxt;
            timer       <= (nxt != st) ? '0 : (&timer) ? timer : timer + CNT_W'(1);
            ped_pending <= (nxt == PED_WALK && st != PED_WALK) ? 1'b0 :
                           (ped_req && st != PED_WALK) ? 1'b1 : ped_pending;
            last_road   <= (st == A_GREEN) ? 1'b0 : (st == B_GREEN) ? 1'b1 : last_road;
        end
    end

    // Next-state: green arbitration on sensors/requests, fixed-length clearance phases
    always_comb begin
        nxt = st;
        case (st)
            A_GREEN:   if (emg || (timer >= G_MIN && (tb || ped_pending) && (!ta || timer >= G_MAX)))
                           nxt = A_YELLOW;
            A_YELLOW:  if (timer >= Y_END) nxt = ALLRED_AB;
            ALLRED_AB: if (timer >= AR_END) nxt = emg ? PREEMPT : ped_pending ? PED_WALK : B_GREEN;
            B_GREEN:   if (emg || (timer >= G_MIN && (!tb || ped_pending || timer >= G_MAX)))
                           nxt = B_YELLOW;
            B_YELLOW:  if (timer >= Y_END) nxt = ALLRED_BA;
            ALLRED_BA: if (timer >= AR_END) nxt = emg ? PREEMPT : ped_pending ? PED_WALK : A_GREEN;
            PED_WALK:  if (timer >= W_END) nxt = emg ? PREEMPT : last_road ? A_GREEN : B_GREEN;
`ifdef EMERG_PREEMPT_EN
            PREEMPT:   if (!emg) nxt = A_GREEN;
`endif
            default:   nxt = A_GREEN;
        endcase
    end

    // Moore outputs decoded from the registered state
    always_comb begin
        la      = (st == A_GREEN) ? 2'b10 : (st == A_YELLOW) ? 2'b01 : 2'b00;
        lb      = (st == B_GREEN) ? 2'b10 : (st == B_YELLOW) ? 2'b01 : 2'b00;
        walk    = (st == PED_WALK);
        ped_ack = (st == PED_WALK) && (timer == '0);
        phase   = st;
    end
endmodule

// File: tb/tb_traffic_phase_sched.sv
// tb_traffic_phase_sched: directed segment-table bench for traffic_phase_sched
module tb_traffic_phase_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b0, ta = 1'b0, tb = 1'b0, ped_req = 1'b0, emerg = 1'b0;
    logic [1:0] la, lb;
    logic       walk, ped_ack;
    logic [2:0] phase;

    int n_tot = 0;
    int n_pass = 0;

    traffic_phase_sched dut (
        .clk(clk), .rst(rst), .ta(ta), .tb(tb), .ped_req(ped_req),
`ifdef EMERG_PREEMPT_EN
        .emerg(emerg),
`endif
        .la(la), .lb(lb), .walk(walk), .ped_ack(ped_ack), .phase(phase)
    );

    always #5 clk = ~clk;

    // One record = hold these inputs for len edges; after each edge the DUT must show phase ph.
    // rst and ped are applied on the first edge of the record only.
    typedef struct {
        logic       rst;
        logic       ta;
        logic       tb;
        logic       ped;
        logic       emerg;
        int         len;
        logic [2:0] ph;
        logic       ack;
    } seg_t;

    seg_t vec[$];

    task automatic seg(input logic r, input logic a, input logic b, input logic p, input logic e,
                       input int n, input logic [2:0] ph, input logic ack);
        seg_t s;
        s.rst = r; s.ta = a; s.tb = b; s.ped = p; s.emerg = e; s.len = n; s.ph = ph; s.ack = ack;
        vec.push_back(s);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Idle: main road rests in green
        seg(1, 0, 0, 0, 0, 1, 0, 0);
        seg(0, 0, 0, 0, 0, 50, 0, 0);
        // Side-road demand only
        seg(1, 0, 1, 0, 0, 1, 0, 0);
        seg(0, 0, 1, 0, 0, 7, 0, 0);
        seg(0, 0, 1, 0, 0, 3, 1, 0);
        seg(0, 0, 1, 0, 0, 1, 2, 0);
        seg(0, 0, 1, 0, 0, 20, 3, 0);
        seg(0, 0, 1, 0, 0, 3, 4, 0);
        seg(0, 0, 1, 0, 0, 1, 5, 0);
        seg(0, 0, 1, 0, 0, 8, 0, 0);
        seg(0, 0, 1, 0, 0, 1, 1, 0);
        // Both roads busy: alternate at max green, period 48
        seg(1, 1, 1, 0, 0, 1, 0, 0);
        seg(0, 1, 1, 0, 0, 19, 0, 0);
        seg(0, 1, 1, 0, 0, 3, 1, 0);
        seg(0, 1, 1, 0, 0, 1, 2, 0);
        seg(0, 1, 1, 0, 0, 20, 3, 0);
        seg(0, 1, 1, 0, 0, 3, 4, 0);
        seg(0, 1, 1, 0, 0, 1, 5, 0);
        seg(0, 1, 1, 0, 0, 20, 0, 0);
        seg(0, 1, 1, 0, 0, 1, 1, 0);
        // Pedestrian pulse; requests on walk entry and during walk are ignored
        seg(1, 0, 0, 0, 0, 1, 0, 0);
        seg(0, 0, 0, 1, 0, 7, 0, 0);
        seg(0, 0, 0, 0, 0, 3, 1, 0);
        seg(0, 0, 0, 0, 0, 1, 2, 0);
        seg(0, 0, 0, 1, 0, 1, 6, 1);
        seg(0, 0, 0, 1, 0, 5, 6, 0);
        seg(0, 0, 0, 0, 0, 8, 3, 0);
        seg(0, 0, 0, 0, 0, 3, 4, 0);
        seg(0, 0, 0, 0, 0, 1, 5, 0);
        seg(0, 0, 0, 0, 0, 12, 0, 0);
        // Reset in 2nd cycle of B_YELLOW with a pending request discards it
        seg(1, 0, 1, 0, 0, 1, 0, 0);
        seg(0, 0, 1, 0, 0, 7, 0, 0);
        seg(0, 0, 1, 0, 0, 3, 1, 0);
        seg(0, 0, 1, 0, 0, 1, 2, 0);
        seg(0, 0, 1, 0, 0, 20, 3, 0);
        seg(0, 0, 1, 1, 0, 1, 4, 0);
        seg(1, 0, 0, 0, 0, 1, 0, 0);
        seg(0, 0, 0, 0, 0, 30, 0, 0);
`ifdef EMERG_PREEMPT_EN
        // Emergency on cycle 3 of B_GREEN, held 10 cycles
        seg(1, 0, 1, 0, 0, 1, 0, 0);
        seg(0, 0, 1, 0, 0, 7, 0, 0);
        seg(0, 0, 1, 0, 0, 3, 1, 0);
        seg(0, 0, 1, 0, 0, 1, 2, 0);
        seg(0, 0, 1, 0, 0, 3, 3, 0);
        seg(0, 0, 0, 0, 1, 3, 4, 0);
        seg(0, 0, 0, 0, 1, 1, 5, 0);
        seg(0, 0, 0, 0, 1, 6, 7, 0);
        seg(0, 0, 0, 0, 0, 5, 0, 0);
`endif

        for (int i = 0; i < vec.size(); i++) begin
            for (int k = 0; k < vec[i].len; k++) begin
                logic [1:0] ela, elb;
                rst     = vec[i].rst && k == 0;
                ped_req = vec[i].ped && k == 0;
                ta      = vec[i].ta;
                tb      = vec[i].tb;
                emerg   = vec[i].emerg;
                step();
                ela = (vec[i].ph == 0) ? 2'b10 : (vec[i].ph == 1) ? 2'b01 : 2'b00;
                elb = (vec[i].ph == 3) ? 2'b10 : (vec[i].ph == 4) ? 2'b01 : 2'b00;
                chk($sformatf("v%0d.%0d phase", i, k), phase, vec[i].ph);
                chk($sformatf("v%0d.%0d la", i, k), la, ela);
                chk($sformatf("v%0d.%0d lb", i, k), lb, elb);
                chk($sformatf("v%0d.%0d walk", i, k), walk, vec[i].ph == 6);
                chk($sformatf("v%0d.%0d ped_ack", i, k), ped_ack, vec[i].ack && k == 0);
            end
        end

        // Held ped_req with busy main road: A waits for max green, then walk, then B
        begin
            int cnt = 0;
            rst = 1'b1; ta = 1'b1; tb = 1'b0; ped_req = 1'b1; emerg = 1'b0;
            step();
            rst = 1'b0;
            while (phase != 3'd6 && cnt < 60) begin
                step();
                cnt++;
            end
            chk("held_ped cycles to walk", cnt, 24);
            chk("held_ped ack", ped_ack, 1);
            ped_req = 1'b0;
            for (int k = 0; k < 5; k++) step();
            chk("held_ped walk end", phase, 6);
            step();
            chk("held_ped after walk", phase, 3);
            chk("held_ped lb green", lb, 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/traffic_phase_sched.md
Name: traffic_phase_sched

Overview:
Timed phase scheduler for the two-road intersection. It sequences lights la/lb through green, yellow and all-red phases using per-phase cycle timers. Green is extended or cut based on the traffic sensors ta/tb, and a latched pedestrian request inserts a walk phase. It replaces the untimed sensor-only FSM with a minimum/maximum-green arbitration scheme: road A is the main road and rests in green; road B is the side road and is served on demand.

Parameters:
GREEN_MIN, 8, minimum green duration in cycles (>=1)
GREEN_MAX, 20, maximum green duration in cycles while the other road has demand (>=GREEN_MIN)
YELLOW_T, 3, yellow duration in cycles (>=1)
ALLRED_T, 1, all-red clearance duration in cycles (>=1)
WALK_T, 6, pedestrian walk duration in cycles (>=1)
CNT_W, 8, phase timer width; every duration parameter must be < 2**CNT_W

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
ta  input  1  traffic present on road A
tb  input  1  traffic present on road B
ped_req  input  1  pedestrian request; a single-cycle pulse or a held level
la  output  2  road A light: 00 red, 01 yellow, 10 green
lb  output  2  road B light: same encoding
walk  output  1  pedestrian walk lamp
ped_ack  output  1  one-cycle pulse on the first cycle of PED_WALK
phase  output  3  current state code (debug/observability)

Behaviour:
- Reset: one clock, synchronous, active-high; rst sampled high at a rising clk edge takes effect at that edge.
- Effect of reset: state=A_GREEN (phase=0), timer=0, ped_pending=0.
- Outputs during/after reset: la=10, lb=00, walk=0, ped_ack=0.
- rst mid-operation overrides any state and any pending request.
- Output timing: all outputs are Moore, decoded from the registered state. They change on the same edge as the state transition; there is no extra latency.
- State codes: A_GREEN=0, A_YELLOW=1, ALLRED_AB=2, B_GREEN=3, B_YELLOW=4, ALLRED_BA=5, PED_WALK=6, PREEMPT=7 (PREEMPT exists only with the macro).
- Lights per state:
  - A_GREEN: la=10, lb=00.
  - A_YELLOW: la=01, lb=00.
  - B_GREEN: la=00, lb=10.
  - B_YELLOW: la=00, lb=01.
  - ALLRED_AB, ALLRED_BA, PED_WALK, PREEMPT: la=lb=00.
  - walk=1 only in PED_WALK.
- Timer: counts cycles spent in the current state. It clears to 0 on every transition and increments otherwise; it saturates and never wraps.
- Duration rule: a state of duration N transitions on the edge where timer==N-1, so it is held exactly N cycles.
- A_GREEN exit to A_YELLOW requires all of:
  - timer>=GREEN_MIN-1;
  - (tb || ped_pending);
  - (!ta || timer>=GREEN_MAX-1).
  - With no demand from B and no pedestrian request, A_GREEN holds indefinitely.
- B_GREEN exit to B_YELLOW requires both:
  - timer>=GREEN_MIN-1;
  - (!tb || ped_pending || timer>=GREEN_MAX-1).
- Fixed-duration transitions:
  - A_YELLOW -> ALLRED_AB after YELLOW_T cycles.
  - B_YELLOW -> ALLRED_BA after YELLOW_T cycles.
- ALLRED_AB after ALLRED_T cycles: goes to PED_WALK if ped_pending, else to B_GREEN.
- ALLRED_BA after ALLRED_T cycles: goes to PED_WALK if ped_pending, else to A_GREEN.
- PED_WALK after WALK_T cycles: goes to the green opposite the road that last had green (after A: B_GREEN; after B: A_GREEN). A 1-bit last_road register tracks this.
- ped_pending:
  - Set by ped_req=1 in any state except PED_WALK; requests during PED_WALK are ignored.
  - Cleared on entry to PED_WALK.
  - Sampling ped_req=1 on the entry edge does not re-set it.
- Sensor sampling: ta and tb are sampled only at evaluation edges. A sensor change during a yellow or all-red phase has no effect on that phase.
- Simultaneous ta=tb=1 with no pedestrian request: the roads alternate at GREEN_MAX for A and GREEN_MAX for B.

Optional Feature:
Macro: EMERG_PREEMPT_EN.
- Port added when defined: emerg (input, 1).
- While emerg=1:
  - A_GREEN and B_GREEN go immediately to their yellow, ignoring GREEN_MIN.
  - A yellow or all-red already in progress completes normally.
  - Every all-red exit goes to PREEMPT instead of its normal target, overriding the walk phase; ped_pending is kept.
- PREEMPT: la=lb=00, walk=0; held while emerg=1.
- PREEMPT exit: on the first edge with emerg=0, go to A_GREEN with timer=0.
- emerg asserted during PED_WALK: the walk completes, then the FSM enters PREEMPT.
- Without the macro: no emerg port, no PREEMPT state; phase code 7 is unreachable.

Test Plan:
- Reset then ta=0, tb=0, no ped_req for 50 cycles -> la=10, lb=00, phase=0 throughout; walk=0, ped_ack=0.
- Reset release then ta=0, tb=1 held -> sequence must be:
  - A_GREEN 8 cycles;
  - A_YELLOW 3 (la=01);
  - ALLRED_AB 1;
  - B_GREEN 20 (lb=10);
  - B_YELLOW 3;
  - ALLRED_BA 1;
  - A_GREEN, 8 cycles before A_YELLOW again.
- ta=1, tb=1 held from reset -> A_GREEN 20 cycles, then 3+1, then B_GREEN 20 cycles; the pattern repeats with period 48 cycles.
- ped_req pulse on cycle 2 of A_GREEN, ta=tb=0 -> sequence must be:
  - A_GREEN exits after 8 cycles, then A_YELLOW 3 and ALLRED_AB 1;
  - PED_WALK 6 cycles with walk=1 and ped_ack=1 on its first cycle only;
  - B_GREEN 8 cycles, yellow, all-red, A_GREEN.
- Assert rst for one edge in the 2nd cycle of B_YELLOW, with ped_pending set -> next cycle la=10, lb=00, phase=0; with ta=tb=0, no walk ever occurs.
- (EMERG_PREEMPT_EN) emerg=1 on cycle 3 of B_GREEN, held 10 cycles -> sequence must be:
  - B_YELLOW 3 and ALLRED_BA 1;
  - PREEMPT with la=lb=00 until emerg drops;
  - A_GREEN on the next edge.
